// File: rtl/reg_file_2r1w.sv
// Register file with one write port and two registered read ports, write-to-read
// forwarding and a per-entry written mask. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_2r1w #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_a,
    output logic              rvalid_b
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam bit              FULL    = (DEPTH == (1 << ADDR_W));

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  mask_q;
    logic [DEPTH-1:0]  wr_hit;
    logic              waddr_ok;
    logic              wr_ok;

    logic [ADDR_W-1:0] raddr_v  [2];
    logic              raddr_ok [2];
    logic [DATA_W-1:0] rdata_d  [2];
    logic [DATA_W-1:0] rdata_q  [2];
    logic              rvalid_d [2];
    logic              rvalid_q [2];

    assign raddr_v[0] = raddr_a;
    assign raddr_v[1] = raddr_b;

    // Range checks only exist when DEPTH leaves unused address codes.
    if (FULL) begin : g_full
        assign waddr_ok    = 1'b1;
        assign raddr_ok[0] = 1'b1;
        assign raddr_ok[1] = 1'b1;
    end else begin : g_partial
        assign waddr_ok    = ({1'b0, waddr}      < DEPTH_C);
        assign raddr_ok[0] = ({1'b0, raddr_v[0]} < DEPTH_C);
        assign raddr_ok[1] = ({1'b0, raddr_v[1]} < DEPTH_C);
    end

`ifdef REGFILE_ZERO_REG_EN
    assign wr_ok = we && waddr_ok && (waddr != '0);
`else
    assign wr_ok = we && waddr_ok;
`endif

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
        assign wr_hit[gi] = wr_ok && (waddr == ADDR_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            mask_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    mem_q[i] <= wdata;
                end
            end
            mask_q <= mask_q | wr_hit;
        end
    end

    for (gi = 0; gi < 2; gi++) begin : g_rd_port
        always_comb begin
            rdata_d[gi]  = '0;
            rvalid_d[gi] = 1'b0;
            if (raddr_ok[gi]) begin
                rdata_d[gi]  = mem_q[raddr_v[gi]];
                rvalid_d[gi] = mask_q[raddr_v[gi]];
            end
            // A write landing on the same edge wins over the stale array contents.
            if (wr_ok && (waddr == raddr_v[gi])) begin
                rdata_d[gi]  = wdata;
                rvalid_d[gi] = 1'b1;
            end
`ifdef REGFILE_ZERO_REG_EN
            if (raddr_v[gi] == '0) begin
                rdata_d[gi]  = '0;
                rvalid_d[gi] = 1'b1;
            end
`endif
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q[gi]  <= '0;
                rvalid_q[gi] <= 1'b0;
            end else begin
                rdata_q[gi]  <= rdata_d[gi];
                rvalid_q[gi] <= rvalid_d[gi];
            end
        end
    end

    assign rdata_a  = rdata_q[0];
    assign rdata_b  = rdata_q[1];
    assign rvalid_a = rvalid_q[0];
    assign rvalid_b = rvalid_q[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: an 8-entry and a 6-entry instance share one stimulus stream
// and are checked every cycle against an array model, plus directed literal checks.
module tb_reg_file_2r1w;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       we;
    logic [2:0] waddr;
    logic [3:0] wdata;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;

    logic [3:0] rd8_a, rd8_b, rd6_a, rd6_b;
    logic       rv8_a, rv8_b, rv6_a, rv6_b;

    reg_file_2r1w #(.DATA_W(4), .DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd8_a), .rdata_b(rd8_b), .rvalid_a(rv8_a), .rvalid_b(rv8_b)
    );

    reg_file_2r1w #(.DATA_W(4), .DEPTH(6)) dut6 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd6_a), .rdata_b(rd6_b), .rvalid_a(rv6_a), .rvalid_b(rv6_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: index 0 is the DEPTH=8 instance, index 1 the DEPTH=6 instance.
    int         depth_m [2] = '{8, 6};
    logic [3:0] mem_m   [2][8];
    bit         wr_m    [2][8];
    logic [3:0] exp_rd  [2][2];
    bit         exp_rv  [2][2];

    function automatic void model_read(input int k, input int addr,
                                       output logic [3:0] d, output bit v);
        if (ZERO_EN && addr == 0) begin
            d = 4'h0; v = 1'b1;
        end else if (addr >= depth_m[k]) begin
            d = 4'h0; v = 1'b0;
        end else if (we && int'(waddr) == addr) begin
            d = wdata; v = 1'b1;
        end else begin
            d = mem_m[k][addr]; v = wr_m[k][addr];
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int e = 0; e < 8; e++) begin
                    mem_m[k][e] = 4'h0;
                    wr_m[k][e]  = 1'b0;
                end
                for (int p = 0; p < 2; p++) begin
                    exp_rd[k][p] = 4'h0;
                    exp_rv[k][p] = 1'b0;
                end
            end else begin
                model_read(k, int'(raddr_a), exp_rd[k][0], exp_rv[k][0]);
                model_read(k, int'(raddr_b), exp_rd[k][1], exp_rv[k][1]);
                if (we && int'(waddr) < depth_m[k] && !(ZERO_EN && waddr == 3'd0)) begin
                    mem_m[k][waddr] = wdata;
                    wr_m[k][waddr]  = 1'b1;
                end
            end
        end
    end

    task automatic cmp(input string name, input int k, input int p,
                       input logic [3:0] got_d, input logic got_v);
        n_vec++;
        if (got_d !== exp_rd[k][p]) begin
            n_fail++;
            $display("FAIL %s dut%0d port%0d rdata got %h want %h at %0t",
                     name, k, p, got_d, exp_rd[k][p], $time);
        end
        n_vec++;
        if (got_v !== exp_rv[k][p]) begin
            n_fail++;
            $display("FAIL %s dut%0d port%0d rvalid got %b want %b at %0t",
                     name, k, p, got_v, exp_rv[k][p], $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model", 0, 0, rd8_a, rv8_a);
            cmp("model", 0, 1, rd8_b, rv8_b);
            cmp("model", 1, 0, rd6_a, rv6_a);
            cmp("model", 1, 1, rd6_b, rv6_b);
        end
    end

    task automatic lit(input string name, input logic [4:0] got, input logic [4:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Applies one cycle of inputs at the falling edge; returns just after the next rising edge.
    task automatic drive(input bit r, input bit w, input logic [2:0] wa, input logic [3:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb, input bit show);
        @(negedge clk);
        reset = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        @(posedge clk);
        #1;
        if (show)
            $display("txn rst=%b we=%b wa=%0d wd=%h ra=%0d rb=%0d -> d8 a=%h/%b b=%h/%b d6 a=%h/%b b=%h/%b",
                     r, w, wa, wd, ra, rb, rd8_a, rv8_a, rd8_b, rv8_b, rd6_a, rv6_a, rd6_b, rv6_b);
    endtask

    initial begin
        logic [3:0] z7;
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

        drive(1, 0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 1);
        lit("reset_a", {rv8_a, rd8_a}, 5'h00);
        lit("reset_b", {rv8_b, rd8_b}, 5'h00);

        for (int a = 0; a < 8; a++) begin
            drive(0, 0, 0, 0, 3'(a), 3'(7 - a), 1);
            lit("empty_a", {rv8_a, rd8_a}, {ZERO_EN && a == 0, 4'h0});
            lit("empty_b", {rv8_b, rd8_b}, {ZERO_EN && a == 7, 4'h0});
        end

        drive(0, 1, 3, 4'hA, 0, 0, 1);
        drive(0, 1, 7, 4'h5, 0, 0, 1);
        drive(0, 0, 0, 0, 3, 7, 1);
        lit("wr_rd_a", {rv8_a, rd8_a}, 5'h1A);
        lit("wr_rd_b", {rv8_b, rd8_b}, 5'h15);
        lit("oor_rd6", {rv6_b, rd6_b}, 5'h00);

        drive(0, 1, 2, 4'h1, 0, 0, 1);
        drive(0, 1, 2, 4'hC, 2, 2, 1);
        lit("fwd_a", {rv8_a, rd8_a}, 5'h1C);
        lit("fwd_b", {rv8_b, rd8_b}, 5'h1C);

        drive(1, 1, 4, 4'hF, 0, 0, 1);
        drive(0, 0, 0, 0, 4, 4, 1);
        lit("rst_vs_wr", {rv8_a, rd8_a}, 5'h00);
        lit("rst_vs_wr6", {rv6_b, rd6_b}, 5'h00);

        drive(0, 1, 0, 4'h3, 0, 0, 1);
        drive(0, 1, 6, 4'h9, 6, 0, 1);
        drive(0, 0, 0, 0, 6, 0, 1);
        lit("oor6_a", {rv6_a, rd6_a}, 5'h00);
        lit("oor6_b", {rv6_b, rd6_b}, ZERO_EN ? 5'h10 : 5'h13);
        lit("inr8_a", {rv8_a, rd8_a}, 5'h19);

        z7 = ZERO_EN ? 4'h0 : 4'h7;
        drive(0, 1, 0, 4'h7, 0, 0, 1);
        lit("zero_same_a", {rv8_a, rd8_a}, {1'b1, z7});
        lit("zero_same_b", {rv8_b, rd8_b}, {1'b1, z7});
        drive(0, 0, 0, 0, 0, 0, 1);
        lit("zero_next_a", {rv8_a, rd8_a}, {1'b1, z7});
        lit("zero_next6", {rv6_b, rd6_b}, {1'b1, z7});

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] wa, ra, rb;
            wa = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, wa,
                  4'($urandom_range(0, 15)), ra, rb, 0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file for the ALU datapath: DEPTH registers of DATA_W bits each, one synchronous write port and two independent registered read ports that feed the ALU A/B operands. It generalises the single 4-bit enabled register to a configurable multi-entry array. It adds read-during-write forwarding and per-entry "written since reset" tracking. An optional hardwired-zero register 0 is available through a compile-time macro.

## Interface
- DATA_W, 4, bits per register (≥1)
- DEPTH, 8, number of registers (2..256; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr_a  in  ADDR_W  read port A address
- raddr_b  in  ADDR_W  read port B address
- rdata_a  out  DATA_W  registered read data, port A
- rdata_b  out  DATA_W  registered read data, port B
- rvalid_a  out  1  registered: entry read on port A has been written since reset
- rvalid_b  out  1  registered: entry read on port B has been written since reset

## Operation
- Storage: DEPTH × DATA_W array plus a DEPTH-bit written mask.
- Reset (reset=1 at an edge):
  - all entries go to 0
  - the written mask goes to 0
  - rdata_a/b go to 0 and rvalid_a/b go to 0
  - reset takes priority over a simultaneous write, which is dropped
- Write: if we=1 and waddr<DEPTH at an edge, entry[waddr] takes wdata and mask[waddr] is set to 1.
- Read, each port independently: at each edge, rdata_x takes entry[raddr_x] and rvalid_x takes mask[raddr_x].
- Forwarding: if we=1, waddr==raddr_x, and the address is in range in the same cycle, rdata_x takes wdata (not the old contents) and rvalid_x takes 1.
- Both ports may read the same address. Both return identical data.
- Out-of-range addresses (≥DEPTH) are possible only when DEPTH is not a power of two:
  - a write to one is ignored, and no entry changes
  - a read of one returns rdata=0 and rvalid=0
- No reset is needed between operations. Contents persist until overwritten or reset.

## Timing
- Write latency: 1 edge. Data written at edge N is readable through the array by an address presented before edge N+1, with rdata valid after edge N+1.
- Read latency: 1 cycle. Address presented in cycle N gives rdata/rvalid valid after edge N and held through cycle N+1.
- Forwarded read: same 1-cycle latency. The new value is visible after the very edge that commits the write.
- Outputs change only on clock edges. There are no combinational paths from inputs to outputs.
- Reset asserted mid-stream: the outputs are 0 after the reset edge. The first post-reset read returns 0/rvalid=0 unless it is forwarded from a write in that cycle.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - entry 0 is hardwired to zero and is never stored
  - writes to address 0 are ignored, and mask[0] stays 0
  - reads of address 0 return rdata=0 and rvalid=1, with no forwarding even when we=1, waddr=0
- REGFILE_ZERO_REG_EN undefined: entry 0 is an ordinary register, identical to every other entry.

## Test plan
- Reset then read: reset=1 for 2 cycles, then read every address on both ports → rdata=0, rvalid=0 throughout.
- Write then read (DATA_W=4, DEPTH=8): write 4'hA→3, 4'h5→7; read A=3, B=7 the next cycle → rdata_a=4'hA, rdata_b=4'h5, both rvalid=1.
- Forwarding: entry 2 holds 4'h1; in one cycle write 4'hC→2 with raddr_a=raddr_b=2 → after that edge rdata_a=rdata_b=4'hC, rvalid=1.
- Reset vs write: we=1, waddr=4, wdata=4'hF with reset=1 at the same edge; read 4 afterwards → rdata=0, rvalid=0.
- Out of range (DEPTH=6): write 4'h9→6, read address 6 and address 0 → rdata=0/rvalid=0 for 6; entry 0 unchanged.
- Zero register (macro defined): write 4'h7→0, read 0 on both ports, including in the same cycle as the write → rdata=0, rvalid=1. Without the macro, the same sequence returns 4'h7, rvalid=1.
